// File: rtl/imem_loader_if.sv
// Byte-stream, fetch and control bundle for the instruction memory loader.
// master = host/core side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] a;
  logic [31:0]       rd;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, len, byte_valid, byte_data, a,
    input  byte_ready, rd, cpu_reset, busy, done, err
  );

  modport slave (
    input  start, len, byte_valid, byte_data, a,
    output byte_ready, rd, cpu_reset, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into instruction RAM, then
// releases the core from reset; RAM is read combinationally.
module imem_loader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t          state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] wcnt;
  logic [1:0]      bcnt;
  logic [23:0]     shift;
  logic [TW-1:0]   tcnt;

  logic            xfer;
  logic            len_ok;
  logic            last_byte;
  logic            last_word;
  logic            tmo;
  logic [31:0]     wword;

  logic [31:0]     mem [DEPTH];

  // {cpu_reset, byte_ready, busy, done} for each state
  function automatic logic [3:0] outs(state_t s);
    logic [3:0] o;
    o = 4'b1000;
    unique case (s)
      LOAD:    o = 4'b1110;
      RUN:     o = 4'b0001;
      default: o = 4'b1000;
    endcase
    return o;
  endfunction

  assign xfer      = bus.byte_valid & bus.byte_ready;
  assign len_ok    = (bus.len != '0) &&
                     (!bus.len[ADDR_W] ||
                      (bus.len[ADDR_W-1:0] == '0));
  assign last_byte = (bcnt == 2'd3);
  assign last_word = ((wcnt + 1'b1) == len_q);
  assign tmo       = (tcnt == TW'(TIMEOUT - 1));
  assign wword     = {shift, bus.byte_data};

  // Load sequencer with registered handshake and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len_q      <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
      shift      <= '0;
      tcnt       <= '0;
      bus.err    <= 1'b0;
      {bus.cpu_reset, bus.byte_ready,
       bus.busy, bus.done} <= outs(IDLE);
    end else begin
      bus.err <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (bus.start) begin
            if (len_ok) begin
              state <= LOAD;
              len_q <= bus.len;
              wcnt  <= '0;
              bcnt  <= '0;
              tcnt  <= '0;
              {bus.cpu_reset, bus.byte_ready,
               bus.busy, bus.done} <= outs(LOAD);
            end else begin
              state   <= IDLE;
              bus.err <= 1'b1;
              {bus.cpu_reset, bus.byte_ready,
               bus.busy, bus.done} <= outs(IDLE);
            end
          end
        end
        LOAD: begin
          unique case (1'b1)
            xfer: begin
              tcnt  <= '0;
              bcnt  <= bcnt + 2'd1;
              shift <= {shift[15:0], bus.byte_data};
              if (last_byte) begin
                wcnt <= wcnt + 1'b1;
                if (last_word) begin
                  state <= RUN;
                  {bus.cpu_reset, bus.byte_ready,
                   bus.busy, bus.done} <= outs(RUN);
                end
              end
            end
            tmo: begin
              state   <= IDLE;
              bcnt    <= '0;
              tcnt    <= '0;
              bus.err <= 1'b1;
              {bus.cpu_reset, bus.byte_ready,
               bus.busy, bus.done} <= outs(IDLE);
            end
            default: tcnt <= tcnt + 1'b1;
          endcase
        end
        default: begin
          state <= IDLE;
          {bus.cpu_reset, bus.byte_ready,
           bus.busy, bus.done} <= outs(IDLE);
        end
      endcase
    end
  end

  // Word write on the edge that takes the 4th byte; RAM has no reset
  always_ff @(posedge clk) begin
    if (xfer && last_byte)
      mem[wcnt[ADDR_W-1:0]] <= wword;
  end

  assign bus.rd = mem[bus.a];

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a word-level
// reference image of the instruction RAM.
module tb_imem_loader;

  localparam int AW    = 6;
  localparam int TO    = 32;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(
    .ADDR_W(AW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] ref_mem [DEPTH];
  bit          known [DEPTH];
  int          total = 0;
  int          bad = 0;
  int          err_seen = 0;

  always @(negedge clk)
    if (bus.err === 1'b1) err_seen++;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int l);
    bus.start = 1'b1;
    bus.len   = l[AW:0];
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b);
    int n;
    n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("byte_wait", 32'd0, 32'd1);
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic check_ram();
    for (int i = 0; i < DEPTH; i++) begin
      if (known[i]) begin
        bus.a = i[AW-1:0];
        #1;
        chk($sformatf("rd[%0d]", i), bus.rd, ref_mem[i]);
      end
    end
  endtask

  task automatic check_status(string tag, logic cr,
                              logic br, logic bz, logic dn);
    chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(cr));
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'(br));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(bz));
    chk({tag, "_done"}, 32'(bus.done), 32'(dn));
  endtask

  task automatic load_words(logic [31:0] w[$], int maxgap,
                            bit inject);
    logic [31:0] cur;
    do_start(w.size());
    chk("load_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < w.size(); i++) begin
      cur = w[i];
      for (int k = 0; k < 4; k++) begin
        if (inject && i == 10 && k == 0) begin
          bus.start = 1'b1;
          bus.len   = '0;
          tick();
          bus.start = 1'b0;
          chk("start_in_load_busy", 32'(bus.busy), 32'd1);
          chk("start_in_load_err", 32'(bus.err), 32'd0);
        end
        repeat ($urandom_range(0, maxgap)) tick();
        send_byte(cur[31:24]);
        cur = cur << 8;
      end
      ref_mem[i] = w[i];
      known[i]   = 1'b1;
    end
    check_status("loaded", 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] wq[$];
    int n;
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.a          = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    repeat (3) tick();
    check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_status("idle", 1'b1, 1'b0, 1'b0, 1'b0);

    wq = '{32'h8C010004, 32'h20020005};
    load_words(wq, 0, 1'b0);
    check_ram();

    do_start(0);
    chk("len0_err", 32'(bus.err), 32'd1);
    check_status("len0", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("len0_err_end", 32'(bus.err), 32'd0);
    do_start(65);
    chk("len65_err", 32'(bus.err), 32'd1);
    check_status("len65", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("len65_err_end", 32'(bus.err), 32'd0);
    check_ram();

    do_start(1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    n = 0;
    while (bus.err !== 1'b1 && n < TO + 10) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TO));
    check_status("timeout", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("timeout_err_end", 32'(bus.err), 32'd0);
    check_ram();

    wq = {};
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
    load_words(wq, 5, 1'b1);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    repeat (4) tick();
    bus.byte_valid = 1'b0;
    check_status("run_idle_bytes", 1'b0, 1'b0, 1'b0, 1'b1);
    check_ram();

    do_start(3);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    ref_mem[0] = 32'h11223344;
    #2;
    reset = 1'b0;
    #1;
    check_status("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("async_rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_ram();
    wq = '{32'hA1B2C3D4};
    load_words(wq, 2, 1'b0);
    check_ram();

    do_start(1);
    chk("reload_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    bus.a = '0;
    repeat (3) send_byte(8'hFF);
    #1;
    chk("reload_old_rd", bus.rd, 32'hA1B2C3D4);
    send_byte(8'hFF);
    chk("reload_new_rd", bus.rd, 32'hFFFFFFFF);
    check_status("reload", 1'b0, 1'b0, 1'b0, 1'b1);
    ref_mem[0] = 32'hFFFFFFFF;
    check_ram();

    chk("err_pulses", 32'(err_seen), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
